// File: rtl/bp_be_pkg.sv
// Purpose: shared FP widths, HardFloat recoded-format structs and helpers for the BE FP datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: dword/word widths, sp/dp exponent and significand widths, recoded widths,
//           the sp<->dp recoded exponent offset, recoded sp/dp structs, NaN-box helper.
package bp_be_pkg;

  localparam int dword_width_gp   = 64;
  localparam int word_width_gp    = 32;

  localparam int dp_exp_width_gp  = 11;
  localparam int dp_sig_width_gp  = 53;
  localparam int sp_exp_width_gp  = 8;
  localparam int sp_sig_width_gp  = 24;

  localparam int dp_rec_width_gp  = dp_exp_width_gp + dp_sig_width_gp + 1;
  localparam int sp_rec_width_gp  = sp_exp_width_gp + sp_sig_width_gp + 1;

  // Offset between an sp recoded exponent and the same value's dp recoded
  // exponent (dp_rec_exp = sp_rec_exp + 0x700). The forward upconversion adds
  // it, the narrowing path subtracts it.
  localparam logic [dp_exp_width_gp:0] rec_bias_adj_gp = 12'h700;

  typedef struct packed {
    logic                       sign;
    logic [dp_exp_width_gp:0]   exp;
    logic [dp_sig_width_gp-2:0] fract;
  } bp_hardfloat_rec_dp_s;

  typedef struct packed {
    logic                       sign;
    logic [sp_exp_width_gp:0]   exp;
    logic [sp_sig_width_gp-2:0] fract;
  } bp_hardfloat_rec_sp_s;

  // RISC-V NaN-boxing: a single held in a 64-bit FP register has all upper bits set.
  function automatic logic [dword_width_gp-1:0] nanbox_sp(input logic [word_width_gp-1:0] sp_raw);
    return {{(dword_width_gp-word_width_gp){1'b1}}, sp_raw};
  endfunction

endpackage

// File: rtl/bp_be_rec_dp_to_sp.sv
// Purpose: narrow a dp-recoded value that holds an upconverted single back to sp-recoded form.
// Latency: combinational.
// Backpressure: none.
// Ports: rec_dp_i 65-bit recoded dp operand, rec_sp_o 33-bit recoded sp result.
module bp_be_rec_dp_to_sp
  import bp_be_pkg::*;
(
  input  logic [dp_rec_width_gp-1:0] rec_dp_i,
  output logic [sp_rec_width_gp-1:0] rec_sp_o
);

  bp_hardfloat_rec_dp_s   dp;
  bp_hardfloat_rec_sp_s   sp;
  logic [2:0]             code;
  logic [dp_exp_width_gp:0] exp_adj;
  logic                   unused_bits;

  assign dp      = rec_dp_i;
  assign code    = dp.exp[dp_exp_width_gp -: 3];
  assign exp_adj = dp.exp - rec_bias_adj_gp;

  always_comb begin
    sp.sign  = dp.sign;
    // An upconverted single only populates the top 23 fraction bits.
    sp.fract = dp.fract[dp_sig_width_gp-2 -: (sp_sig_width_gp-1)];
    // Zero and inf/NaN keep their class code; the low exponent bits are copied
    // as-is. Everything else is a genuine exponent and is rebased.
    if ((code == 3'd0) || (code >= 3'd6)) begin
      sp.exp = {code, dp.exp[5:0]};
    end else begin
      sp.exp = exp_adj[sp_exp_width_gp:0];
    end
  end

  assign rec_sp_o = sp;

  assign unused_bits = ^{dp.fract[dp_sig_width_gp-sp_sig_width_gp-1:0],
                         exp_adj[dp_exp_width_gp:sp_exp_width_gp+1]};

endmodule

// File: rtl/bsg_dff_en.sv
// Purpose: plain enabled register bank, no reset (used for pipeline data).
// Latency: 1 cycle when en_i is high.
// Backpressure: none; holds its value while en_i is low.
// Ports: clk_i clock, en_i load enable, data_i next value, data_o registered value.
module bsg_dff_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/recFNToFN.sv
// Purpose: HardFloat-style conversion from recoded FP (expWidth+sigWidth+1 bits) to IEEE raw.
// Latency: combinational.
// Backpressure: none.
// Ports: in recoded value {sign, exp[expWidth:0], fract[sigWidth-2:0]}, out IEEE raw value.
module recFNToFN #(
  parameter int expWidth = 8,
  parameter int sigWidth = 24
) (
  input  logic [expWidth+sigWidth:0]   in,
  output logic [expWidth+sigWidth-1:0] out
);

  // Smallest recoded exponent of a normal number, and the offset from a
  // recoded normal exponent back to the IEEE biased exponent.
  localparam logic [expWidth:0] min_norm_exp = (expWidth+1)'((1 << (expWidth-1)) + 2);
  localparam logic [expWidth:0] norm_exp_adj = (expWidth+1)'((1 << (expWidth-1)) + 1);

  logic                  sign;
  logic [expWidth:0]     rec_exp;
  logic [sigWidth-2:0]   rec_fract;
  logic                  is_zero;
  logic                  is_special;
  logic                  is_nan;
  logic                  is_subnormal;
  logic [expWidth:0]     denorm_shift;
  logic [expWidth:0]     norm_exp;
  logic [sigWidth-1:0]   denorm_sig;
  logic [expWidth-1:0]   exp_out;
  logic [sigWidth-2:0]   fract_out;
  logic                  unused_bits;

  assign {sign, rec_exp, rec_fract} = in;

  // The top three exponent bits carry the class: 000 zero, 11x inf/NaN.
  assign is_zero      = (rec_exp[expWidth -: 3] == 3'b000);
  assign is_special   = (rec_exp[expWidth -: 2] == 2'b11);
  assign is_nan       = is_special & rec_exp[expWidth-2];
  assign is_subnormal = (rec_exp < min_norm_exp);

  // Subnormals are stored normalised; shift the implicit one back down.
  assign denorm_shift = min_norm_exp - rec_exp;
  assign denorm_sig   = {1'b1, rec_fract} >> denorm_shift;
  assign norm_exp     = rec_exp - norm_exp_adj;

  always_comb begin
    exp_out   = norm_exp[expWidth-1:0];
    fract_out = rec_fract;
    if (is_zero) begin
      exp_out   = '0;
      fract_out = '0;
    end else if (is_special) begin
      exp_out   = '1;
      // NaN payload passes through untouched; infinities have a zero fraction.
      fract_out = is_nan ? rec_fract : '0;
    end else if (is_subnormal) begin
      exp_out   = '0;
      fract_out = denorm_sig[sigWidth-2:0];
    end
  end

  assign out = {sign, exp_out, fract_out};

  assign unused_bits = denorm_sig[sigWidth-1] ^ norm_exp[expWidth];

endmodule

// File: rtl/bp_be_rec_to_fp_pipe.sv
// Purpose: recoded FP (dp or upconverted sp) to IEEE raw, singles NaN-boxed, tag carried alongside.
// Latency: 2 cycles (stage 1 narrows sp, stage 2 unrecodes), throughput 1/cycle.
// Backpressure: valid/ready; ready_o = !s1_v | s2 advances (combinational from ready_i), bubbles collapse.
// Ports: clk_i, reset_n_i (sync, active-low); in: v_i/ready_o, rec_i, rec_sp_not_dp_i, tag_i;
//        out: v_o/ready_i, raw_o, raw_sp_not_dp_o, tag_o.
module bp_be_rec_to_fp_pipe
  import bp_be_pkg::*;
#(
  parameter int tag_width_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [dp_rec_width_gp-1:0] rec_i,
  input  logic                       rec_sp_not_dp_i,
  input  logic [tag_width_p-1:0]     tag_i,

  output logic                       v_o,
  input  logic                       ready_i,
  output logic [dword_width_gp-1:0]  raw_o,
  output logic                       raw_sp_not_dp_o,
  output logic [tag_width_p-1:0]     tag_o
);

  // Handshake / occupancy
  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic s1_adv, s2_adv;
  logic s1_en, s2_en;

  assign s2_adv  = ~s2_v_q | ready_i;
  assign s1_adv  = ~s1_v_q | s2_adv;
  assign ready_o = s1_adv;

  // A stage's data register loads only when a valid item moves into it.
  assign s1_en  = v_i & s1_adv;
  assign s2_en  = s1_v_q & s2_adv;

  assign s1_v_d = s1_adv ? v_i    : s1_v_q;
  assign s2_v_d = s2_adv ? s1_v_q : s2_v_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  // Stage 1: narrow singles, pass doubles through
  logic [sp_rec_width_gp-1:0] rec_sp_narrow;
  logic [dp_rec_width_gp-1:0] s1_rec_d, s1_rec_q;
  logic                       s1_sp_q;
  logic [tag_width_p-1:0]     s1_tag_q;

  bp_be_rec_dp_to_sp narrow (
    .rec_dp_i (rec_i),
    .rec_sp_o (rec_sp_narrow)
  );

  // The sp value sits in the low bits of the stage register.
  assign s1_rec_d = rec_sp_not_dp_i
                  ? {{(dp_rec_width_gp-sp_rec_width_gp){1'b0}}, rec_sp_narrow}
                  : rec_i;

  bsg_dff_en #(
    .width_p (dp_rec_width_gp + 1 + tag_width_p)
  ) s1_reg (
    .clk_i  (clk_i),
    .en_i   (s1_en),
    .data_i ({s1_rec_d, rec_sp_not_dp_i, tag_i}),
    .data_o ({s1_rec_q, s1_sp_q, s1_tag_q})
  );

  // Stage 2: unrecode
  logic [word_width_gp-1:0]  sp_raw;
  logic [dword_width_gp-1:0] dp_raw;
  logic [dword_width_gp-1:0] s2_raw_d;

  recFNToFN #(
    .expWidth (sp_exp_width_gp),
    .sigWidth (sp_sig_width_gp)
  ) sp_unrec (
    .in  (s1_rec_q[sp_rec_width_gp-1:0]),
    .out (sp_raw)
  );

  recFNToFN #(
    .expWidth (dp_exp_width_gp),
    .sigWidth (dp_sig_width_gp)
  ) dp_unrec (
    .in  (s1_rec_q),
    .out (dp_raw)
  );

  assign s2_raw_d = s1_sp_q ? nanbox_sp(sp_raw) : dp_raw;

  bsg_dff_en #(
    .width_p (dword_width_gp + 1 + tag_width_p)
  ) s2_reg (
    .clk_i  (clk_i),
    .en_i   (s2_en),
    .data_i ({s2_raw_d, s1_sp_q, s1_tag_q}),
    .data_o ({raw_o, raw_sp_not_dp_o, tag_o})
  );

  assign v_o = s2_v_q;

endmodule

// File: tb/tb_bp_be_rec_to_fp_pipe.sv
`timescale 1ns/1ps
module tb_bp_be_rec_to_fp_pipe;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_o;
  logic [64:0] rec_i;
  logic        rec_sp_not_dp_i;
  logic [7:0]  tag_i;
  logic        v_o;
  logic        ready_i;
  logic [63:0] raw_o;
  logic        raw_sp_not_dp_o;
  logic [7:0]  tag_o;

  always #5 clk_i = ~clk_i;

  bp_be_rec_to_fp_pipe #(.tag_width_p(8)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .v_i             (v_i),
    .ready_o         (ready_o),
    .rec_i           (rec_i),
    .rec_sp_not_dp_i (rec_sp_not_dp_i),
    .tag_i           (tag_i),
    .v_o             (v_o),
    .ready_i         (ready_i),
    .raw_o           (raw_o),
    .raw_sp_not_dp_o (raw_sp_not_dp_o),
    .tag_o           (tag_o)
  );

  typedef struct packed {
    logic [63:0] raw;
    logic        sp;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic hold_pending = 1'b0;
  exp_t held;
  logic rand_done = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Producer-side model: IEEE raw -> recoded, and sp-recoded -> dp-recoded.
  function automatic logic [32:0] sp_to_rec(input logic [31:0] r);
    logic [7:0]  e;
    logic [22:0] f, rf;
    logic [8:0]  re;
    int          p;
    e = r[30:23]; f = r[22:0]; rf = f; p = 0;
    re = {1'b0, e} + 9'd129;
    if (e == 8'h00) begin
      if (f == 23'h0) begin
        re = 9'h0; rf = 23'h0;
      end else begin
        for (int i = 0; i < 23; i++) if (f[i]) p = i;
        rf = f << (23 - p);
        re = 9'(p + 107);
      end
    end else if (e == 8'hFF) begin
      re = (f != 23'h0) ? 9'h1C0 : 9'h180;
    end
    return {r[31], re, rf};
  endfunction

  function automatic logic [64:0] dp_to_rec(input logic [63:0] r);
    logic [10:0] e;
    logic [51:0] f, rf;
    logic [11:0] re;
    int          p;
    e = r[62:52]; f = r[51:0]; rf = f; p = 0;
    re = {1'b0, e} + 12'd1025;
    if (e == 11'h000) begin
      if (f == 52'h0) begin
        re = 12'h0; rf = 52'h0;
      end else begin
        for (int i = 0; i < 52; i++) if (f[i]) p = i;
        rf = f << (52 - p);
        re = 12'(p + 974);
      end
    end else if (e == 11'h7FF) begin
      re = (f != 52'h0) ? 12'hE00 : 12'hC00;
    end
    return {r[63], re, rf};
  endfunction

  function automatic logic [64:0] up_sp(input logic [32:0] s);
    logic [2:0]  code;
    logic [11:0] de;
    code = s[31:29];
    if ((code == 3'd0) || (code >= 3'd6)) de = {code, 3'b000, s[28:23]};
    else                                  de = {3'b000, s[31:23]} + 12'h700;
    return {s[32], de, s[22:0], 29'h0};
  endfunction

  // Drives one item from posedge+1 until accepted; pushes the expectation at the accepting edge.
  task automatic issue(input logic [64:0] a_rec, input logic a_sp, input logic [7:0] a_tag,
                       input logic [63:0] a_raw);
    logic acc;
    int   waits;
    acc = 1'b0; waits = 0;
    v_i = 1'b1; rec_i = a_rec; rec_sp_not_dp_i = a_sp; tag_i = a_tag;
    while (!acc && waits < 200) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      if (acc) sb_q.push_back('{raw: a_raw, sp: a_sp, tag: a_tag});
      else     waits++;
    end
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: ready_o stayed %0b, required 1 within 200 cycles", ready_o);
    end
    #1 v_i = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    do begin
      @(posedge clk_i);
      t++;
    end while (sb_q.size() != 0 && t < 500);
    check("drain_queue_empty", 80'(sb_q.size()), 80'd0);
    #1;
  endtask

  // Monitor: compares every delivered item against the scoreboard, and checks
  // that a stalled output holds still.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_v_o", 80'(v_o), 80'd1);
          check("hold_data", 80'({raw_o, raw_sp_not_dp_o, tag_o}), 80'(held));
          hold_pending = 1'b0;
        end
        if (v_o && ready_i) begin
          if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: got raw %h tag %h, required no output", raw_o, tag_o);
          end else begin
            e = sb_q.pop_front();
            check("out_raw_flag_tag", 80'({raw_o, raw_sp_not_dp_o, tag_o}), 80'(e));
          end
        end else if (v_o) begin
          held = '{raw: raw_o, sp: raw_sp_not_dp_o, tag: tag_o};
          hold_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r32;
    logic [63:0] r64;
    time         t0;

    reset_n_i = 1'b0; v_i = 1'b0; rec_i = '0; rec_sp_not_dp_i = 1'b0; tag_i = '0; ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    @(negedge clk_i);
    check("reset_v_o", 80'(v_o), 80'd0);
    check("reset_ready_o", 80'(ready_o), 80'd1);
    @(posedge clk_i); #1;
    ready_i = 1'b1;

    // sp 1.0: invisible one edge after capture, visible after the next
    issue({1'b0, 12'h800, 52'h0}, 1'b1, 8'h05, 64'hFFFFFFFF_3F800000);
    @(negedge clk_i);
    check("latency_v_o_edge1", 80'(v_o), 80'd0);
    @(negedge clk_i);
    check("latency_v_o_edge2", 80'(v_o), 80'd1);
    @(posedge clk_i); #1;

    // dp 1.0, sp -inf, sp canonical NaN back to back
    t0 = $time;
    issue({1'b0, 12'h800, 52'h0}, 1'b0, 8'h10, 64'h3FF00000_00000000);
    issue({1'b1, 12'hC00, 52'h0}, 1'b1, 8'h11, 64'hFFFFFFFF_FF800000);
    issue({1'b0, 12'hE00, 23'h400000, 29'h0}, 1'b1, 8'h12, 64'hFFFFFFFF_7FC00000);
    check("b2b_accept_cycles", 80'(($time - t0) / 10), 80'd3);

    // sp +0, sp smallest subnormal, NaN payloads (sp and dp)
    issue({1'b0, 12'h000, 52'h0}, 1'b1, 8'h20, 64'hFFFFFFFF_00000000);
    issue({1'b0, 12'h76B, 52'h0}, 1'b1, 8'h21, 64'hFFFFFFFF_00000001);
    issue({1'b0, 12'hE00, 23'h012345, 29'h0}, 1'b1, 8'h22, 64'hFFFFFFFF_7F812345);
    issue({1'b0, 12'hE00, 52'h8_0000_0000_0001}, 1'b0, 8'h23, 64'h7FF80000_00000001);
    wait_drain();

    // Stall: ready_i low for 5 cycles while streaming 3 items
    ready_i = 1'b0;
    fork
      begin
        issue({1'b0, 12'h801, 52'h0}, 1'b1, 8'h30, 64'hFFFFFFFF_40000000);
        issue({1'b1, 12'h801, 52'h4_0000_0000_0000}, 1'b0, 8'h31, 64'hC0040000_00000000);
        issue({1'b0, 12'h7FF, 52'h0}, 1'b1, 8'h32, 64'hFFFFFFFF_3F000000);
      end
      begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("stall_ready_o", 80'(ready_o), 80'd0);
        check("stall_v_o", 80'(v_o), 80'd1);
        repeat (2) @(posedge clk_i);
        #1 ready_i = 1'b1;
      end
    join
    wait_drain();

    // Reset with two items in flight
    ready_i = 1'b0;
    issue({1'b0, 12'h800, 52'h0}, 1'b1, 8'hAA, 64'hFFFFFFFF_3F800000);
    issue({1'b0, 12'h800, 52'h0}, 1'b0, 8'hBB, 64'h3FF00000_00000000);
    reset_n_i = 1'b0;
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    sb_q.delete();
    @(negedge clk_i);
    check("midreset_v_o", 80'(v_o), 80'd0);
    check("midreset_ready_o", 80'(ready_o), 80'd1);
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("midreset_no_output", 80'(v_o), 80'd0);
    end
    @(posedge clk_i); #1;

    // Random round trip through the producer model with random ready_i
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 1) == 0) begin
            r32 = $urandom;
            case ($urandom_range(0, 4))
              0: r32[30:23] = 8'h00;
              1: begin
                r32[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) r32[22:0] = 23'h0;
              end
              2: r32[22:0] = (r32[0]) ? 23'h0 : 23'h1;
              default: ;
            endcase
            issue(up_sp(sp_to_rec(r32)), 1'b1, 8'($urandom), {32'hFFFFFFFF, r32});
          end else begin
            r64 = {$urandom, $urandom};
            case ($urandom_range(0, 4))
              0: r64[62:52] = 11'h000;
              1: begin
                r64[62:52] = 11'h7FF;
                if ($urandom_range(0, 1) == 0) r64[51:0] = 52'h0;
              end
              2: r64[51:0] = (r64[0]) ? 52'h0 : 52'h1;
              default: ;
            endcase
            issue(dp_to_rec(r64), 1'b0, 8'($urandom), r64);
          end
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk_i); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk_i);
          #1 ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_i = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
